// File: rtl/bram_pkg.sv
// Shared types and helpers for block RAM initiators.
package bram_pkg;

    localparam int unsigned BRAM_DW = 32;
    localparam int unsigned BRAM_BW = 4;

    typedef struct packed {
        logic               wr;
        logic [BRAM_DW-1:0] data;
    } bram_rsp_t;

    // Byte address to 32-bit word index.
    function automatic logic [31:0] byte2word(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

endpackage

// File: rtl/bram_req_master_if.sv
// Request/response valid-ready channel between the front end and bram_req_master.
interface bram_req_master_if;
    import bram_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [BRAM_BW-1:0]        req_we;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [BRAM_DW-1:0]        rsp_rdata;
    logic                      rsp_wr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_wr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_wr
    );

endinterface

// File: rtl/bram_rsp_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count and head-of-queue output.
module bram_rsp_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 33
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [$clog2(Depth):0]   count_o,
    output logic [Width-1:0]         head_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge CLK) begin
        if (!RST && push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_i && !pop_i) begin
                count_q <= count_q + CntW'(1);
            end else if (!push_i && pop_i) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_req_master.sv
// Valid/ready initiator for a single-port byte-writable BRAM with a buffered
// one-cycle-latency read path.
module bram_req_master
    import bram_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 2,
    parameter bit          BYTE_ADDR = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    bram_req_master_if.slave    bus,
    output logic                bram_en_o,
    output logic [BRAM_BW-1:0]  bram_we_o,
    output logic [31:0]         bram_a_o,
    output logic [BRAM_DW-1:0]  bram_di_o,
    input  logic [BRAM_DW-1:0]  bram_do_i
);

    localparam int unsigned CntW = $clog2(RSP_DEPTH) + 1;
    localparam logic [CntW:0] DepthCmp = (CntW + 1)'(RSP_DEPTH);

    logic            accept;
    logic            pop;
    logic            inflight_q;
    logic            inflight_wr_q;
    logic [CntW-1:0] count;
    logic [CntW:0]   occ;
    bram_rsp_t       push_data;
    bram_rsp_t       head;

    // Reserve a FIFO slot for every access whose data has not landed yet, so
    // the one-cycle-only RAM output can always be captured.
    assign occ = {1'b0, count} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);

    assign bus.req_ready = !RST && (occ < DepthCmp);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bram_en_o = accept;
    assign bram_we_o = accept ? bus.req_we : '0;
    assign bram_a_o  = RST ? '0 : (BYTE_ADDR ? byte2word(bus.req_addr) : bus.req_addr);
    assign bram_di_o = RST ? '0 : bus.req_wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            inflight_q    <= 1'b0;
            inflight_wr_q <= 1'b0;
        end else begin
            inflight_q    <= accept;
            inflight_wr_q <= accept && (|bus.req_we);
        end
    end

    assign push_data = '{wr: inflight_wr_q, data: bram_do_i};

    bram_rsp_fifo #(
        .Depth (RSP_DEPTH),
        .Width ($bits(bram_rsp_t))
    ) u_rsp_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (inflight_q),
        .data_i  (push_data),
        .pop_i   (pop),
        .count_o (count),
        .head_o  (head)
    );

    assign bus.rsp_valid = !RST && (count != '0);
    assign bus.rsp_rdata = head.data;
    assign bus.rsp_wr    = head.wr;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

endmodule
